branch_resolver: RTL

//  Pipeline-side initiator for the 2-bit branch predictor: issues a predict request per fetched branch,

---
 rtl/bp_pkg.sv | 10 +
 rtl/branch_resolver_if.sv | 32 +++
 rtl/bp_sync_fifo.sv | 80 ++++++++
 rtl/branch_resolver.sv | 104 ++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
package bp_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef struct packed {
    logic pred;
  } fifo_entry_t;

endpackage

// File: rtl/branch_resolver_if.sv
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 16
);

  logic             br_fetch;
  logic             br_resolve;
  logic             br_actual;
  logic             pred_request;
  logic             pred_in;
  logic             upd_result;
  logic             upd_taken;
  logic             fetch_pred_valid;
  logic             fetch_pred;
  logic             stall;
  logic             mispredict;
  logic             proto_err;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output br_fetch, br_resolve, br_actual, pred_in,
    input  pred_request, upd_result, upd_taken, fetch_pred_valid, fetch_pred,
    input  stall, mispredict, proto_err, br_count, mp_count
  );

  modport slave (
    input  br_fetch, br_resolve, br_actual, pred_in,
    output pred_request, upd_result, upd_taken, fetch_pred_valid, fetch_pred,
    output stall, mispredict, proto_err, br_count, mp_count
  );

endinterface

// File: rtl/bp_sync_fifo.sv
module bp_sync_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fifo_entry_t                din,
  output fifo_entry_t                dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    count = count_q;
    dout  = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
module branch_resolver
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic             pending_q, pending_d;
  logic             upd_result_q, upd_result_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  logic             fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  fifo_entry_t      fifo_din, fifo_head;
  logic [AW:0]      fifo_count, in_flight;
  logic             stall, pred_request, res_valid, oldest, mp;

  bp_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    in_flight    = fifo_count + {{AW{1'b0}}, pending_q};
    stall        = (in_flight == FULL_CNT);
    pred_request = bus.br_fetch && !stall;
  end

  always_comb begin
    res_valid     = bus.br_resolve && (!fifo_empty || pending_q);
    oldest        = fifo_empty ? bus.pred_in : fifo_head.pred;
    mp            = res_valid && (oldest != bus.br_actual);
    fifo_din.pred = bus.pred_in;
    fifo_pop      = res_valid && !fifo_empty;
    // A resolve served by the bypass consumes the pending prediction, so it is never pushed.
    fifo_push     = pending_q && !fifo_full && !(res_valid && fifo_empty);
    fifo_clear    = mp;
    pending_d     = pred_request && !mp;
    proto_err_d   = proto_err_q || (bus.br_resolve && fifo_empty && !pending_q);
    upd_result_d  = res_valid;
    upd_taken_d   = res_valid && bus.br_actual;
    mispredict_d  = mp;
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;
    if (res_valid && (br_count_q != '1)) begin
      br_count_d = br_count_q + 1'b1;
    end
    if (mp && (mp_count_q != '1)) begin
      mp_count_d = mp_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      upd_result_q <= 1'b0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      proto_err_q  <= 1'b0;
      br_count_q   <= '0;
      mp_count_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      upd_result_q <= upd_result_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      proto_err_q  <= proto_err_d;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

  assign bus.pred_request     = pred_request;
  assign bus.stall            = stall;
  assign bus.fetch_pred_valid = pending_q;
  assign bus.fetch_pred       = pending_q && bus.pred_in;
  assign bus.upd_result       = upd_result_q;
  assign bus.upd_taken        = upd_taken_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.proto_err        = proto_err_q;
  assign bus.br_count         = br_count_q;
  assign bus.mp_count         = mp_count_q;

endmodule
